// File: rtl/uart_wb_cfg_arb_if.sv
// Bus bundle for uart_wb_cfg_arb: host port, UART register port
// and configuration request/status lines.
interface uart_wb_cfg_arb_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  h_cyc_i;
  logic                  h_stb_i;
  logic                  h_we_i;
  logic [ADDR_WIDTH-1:0] h_adr_i;
  logic [7:0]            h_dat_i;
  logic [7:0]            h_dat_o;
  logic                  h_ack_o;
  logic                  h_err_o;

  logic                  s_cyc_o;
  logic                  s_stb_o;
  logic                  s_we_o;
  logic [ADDR_WIDTH-1:0] s_adr_o;
  logic [7:0]            s_dat_o;
  logic [7:0]            s_dat_i;
  logic                  s_ack_i;

  logic                  cfg_start_i;
  logic [15:0]           cfg_divisor_i;
  logic                  cfg_busy_o;
  logic                  cfg_done_o;
  logic                  cfg_err_o;

  modport slave (
    input  h_cyc_i, h_stb_i, h_we_i, h_adr_i, h_dat_i,
    output h_dat_o, h_ack_o, h_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i,
    input  cfg_start_i, cfg_divisor_i,
    output cfg_busy_o, cfg_done_o, cfg_err_o
  );

  modport master (
    output h_cyc_i, h_stb_i, h_we_i, h_adr_i, h_dat_i,
    input  h_dat_o, h_ack_o, h_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i,
    output cfg_start_i, cfg_divisor_i,
    input  cfg_busy_o, cfg_done_o, cfg_err_o
  );
endinterface

// File: rtl/uart_wb_cfg_arb.sv
// Wishbone controller for the 8-bit UART register port: runs the
// LCR/DLL/DLM/FCR init sequence and shares the port with one host.
module uart_wb_cfg_arb #(
  parameter int          ADDR_WIDTH    = 5,
  parameter logic [7:0]  LCR_VAL       = 8'h03,
  parameter logic [7:0]  FCR_VAL       = 8'hC7,
  parameter logic [15:0] RESET_DIVISOR = 16'd27,
  parameter bit          AUTO_CFG      = 1'b1,
  parameter int          GAP_CYCLES    = 2,
  parameter int          TIMEOUT       = 15
) (
  input logic              clk,
  input logic              wb_rst_n_i,
  uart_wb_cfg_arb_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GL = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int GW = (GL > 0) ? $clog2(GL + 1) : 1;

  typedef enum logic [1:0] {
    IDLE, HOST_XFER, CFG_XFER, GAP
  } state_t;

  state_t state, state_nx;

  logic [2:0]            step, step_d;
  logic [15:0]           div, div_d;
  logic                  busy, busy_d;
  logic                  done, done_d;
  logic                  err, err_d;
  logic                  booted;
  logic                  drop, drop_d;
  logic [TW-1:0]         tmo, tmo_d;
  logic [GW-1:0]         gcnt, gcnt_d;

  logic                  cyc, cyc_d;
  logic                  stb, stb_d;
  logic                  we, we_d;
  logic [ADDR_WIDTH-1:0] adr, adr_d;
  logic [7:0]            wdat, wdat_d;
  logic                  hack, hack_d;
  logic                  herr, herr_d;
  logic [7:0]            hdat, hdat_d;

  logic                  boot_req, start_req, cfg_req;
  logic                  host_req, xfer, tmo_hit, fin;
  logic                  gap_end, quiet;
  logic                  launch_cfg, launch_host;
  logic [ADDR_WIDTH-1:0] cfg_adr;
  logic [7:0]            cfg_dat;

  assign boot_req  = AUTO_CFG && !booted;
  assign start_req = !busy && (boot_req || bus.cfg_start_i);
  assign cfg_req   = busy || start_req;
  assign host_req  = bus.h_cyc_i && bus.h_stb_i;
  assign xfer      = (state == HOST_XFER) ||
                     (state == CFG_XFER);
  assign tmo_hit   = xfer && !bus.s_ack_i &&
                     (tmo == TW'(TIMEOUT - 1));
  assign fin       = xfer && (bus.s_ack_i || tmo_hit);
  assign gap_end   = (gcnt == GW'(GL));
  // a host that let go of cyc gets no response
  assign quiet     = drop || !bus.h_cyc_i;

  assign launch_cfg  = (state_nx == CFG_XFER) &&
                       (state != CFG_XFER);
  assign launch_host = (state_nx == HOST_XFER) &&
                       (state != HOST_XFER);

  always_comb begin
    cfg_adr = ADDR_WIDTH'(2);
    cfg_dat = FCR_VAL;
    unique case (1'b1)
      (step == 3'd0): begin
        cfg_adr = ADDR_WIDTH'(3);
        cfg_dat = LCR_VAL | 8'h80;
      end
      (step == 3'd1): begin
        cfg_adr = ADDR_WIDTH'(0);
        cfg_dat = div[7:0];
      end
      (step == 3'd2): begin
        cfg_adr = ADDR_WIDTH'(1);
        cfg_dat = div[15:8];
      end
      (step == 3'd3): begin
        cfg_adr = ADDR_WIDTH'(3);
        cfg_dat = LCR_VAL & 8'h7F;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (cfg_req)       state_nx = CFG_XFER;
        else if (host_req) state_nx = HOST_XFER;
      end
      HOST_XFER, CFG_XFER: begin
        if (fin) state_nx = GAP;
      end
      GAP: begin
        if (gap_end)
          state_nx = cfg_req ? CFG_XFER : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cyc_d  = cyc;
    stb_d  = stb;
    we_d   = we;
    adr_d  = adr;
    wdat_d = wdat;
    hack_d = 1'b0;
    herr_d = 1'b0;
    hdat_d = hdat;
    step_d = step;
    div_d  = div;
    busy_d = busy;
    done_d = done;
    err_d  = err;
    drop_d = drop;
    gcnt_d = '0;
    tmo_d  = '0;

    if (start_req) begin
      busy_d = 1'b1;
      done_d = 1'b0;
      err_d  = 1'b0;
      step_d = '0;
      div_d  = boot_req ? RESET_DIVISOR
                        : bus.cfg_divisor_i;
    end

    if (xfer)
      tmo_d = (tmo == TW'(TIMEOUT)) ? tmo
                                    : tmo + 1'b1;
    if (state == GAP)
      gcnt_d = gcnt + 1'b1;
    if (state == HOST_XFER && !bus.h_cyc_i)
      drop_d = 1'b1;

    if (fin) begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
      if (state == HOST_XFER && !quiet) begin
        hack_d = bus.s_ack_i;
        herr_d = !bus.s_ack_i;
        if (!bus.s_ack_i) hdat_d = 8'h00;
        else if (!we)     hdat_d = bus.s_dat_i;
      end
      if (state == CFG_XFER) begin
        if (bus.s_ack_i && step == 3'd4) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          step_d = '0;
        end else if (bus.s_ack_i) begin
          step_d = step + 3'd1;
        end else begin
          busy_d = 1'b0;
          err_d  = 1'b1;
          step_d = '0;
        end
      end
    end

    if (launch_cfg) begin
      cyc_d  = 1'b1;
      stb_d  = 1'b1;
      we_d   = 1'b1;
      adr_d  = cfg_adr;
      wdat_d = cfg_dat;
    end
    if (launch_host) begin
      cyc_d  = 1'b1;
      stb_d  = 1'b1;
      we_d   = bus.h_we_i;
      adr_d  = bus.h_adr_i;
      wdat_d = bus.h_dat_i;
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cyc    <= 1'b0;
      stb    <= 1'b0;
      we     <= 1'b0;
      adr    <= '0;
      wdat   <= '0;
      hack   <= 1'b0;
      herr   <= 1'b0;
      hdat   <= '0;
      step   <= '0;
      div    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      booted <= 1'b0;
      drop   <= 1'b0;
      tmo    <= '0;
      gcnt   <= '0;
    end else begin
      cyc    <= cyc_d;
      stb    <= stb_d;
      we     <= we_d;
      adr    <= adr_d;
      wdat   <= wdat_d;
      hack   <= hack_d;
      herr   <= herr_d;
      hdat   <= hdat_d;
      step   <= step_d;
      div    <= div_d;
      busy   <= busy_d;
      done   <= done_d;
      err    <= err_d;
      booted <= 1'b1;
      drop   <= drop_d;
      tmo    <= tmo_d;
      gcnt   <= gcnt_d;
    end
  end

  assign bus.s_cyc_o    = cyc;
  assign bus.s_stb_o    = stb;
  assign bus.s_we_o     = we;
  assign bus.s_adr_o    = adr;
  assign bus.s_dat_o    = wdat;
  assign bus.h_ack_o    = hack;
  assign bus.h_err_o    = herr;
  assign bus.h_dat_o    = hdat;
  assign bus.cfg_busy_o = busy;
  assign bus.cfg_done_o = done;
  assign bus.cfg_err_o  = err;
endmodule

// File: tb/tb_uart_wb_cfg_arb.sv
// Directed + randomized bench for uart_wb_cfg_arb with a
// transaction-level UART slave and host/config reference model.
module tb_uart_wb_cfg_arb;
  localparam int AW = 5;
  localparam logic [7:0] LCR = 8'h03;
  localparam logic [7:0] FCR = 8'hC7;
  localparam logic [15:0] RDIV = 16'd27;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [7:0]    dat;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   ncmp = 0;
  int   nerr = 0;

  uart_wb_cfg_arb_if #(.ADDR_WIDTH(AW)) bus ();

  uart_wb_cfg_arb dut (
    .clk        (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xfer_t         log_q[$];
  int            ack_lat = 2;
  bit            nak_en = 1'b0;
  logic [AW-1:0] nak_adr = '0;
  logic [7:0]    rd_val = 8'h00;
  int            hi_len = 0;
  int            last_len = 0;
  int            idle_run = 0;
  int            min_gap = 1000;
  int            ack_cyc = 0;
  int            s_acks = 0;
  bit            prev_stb = 1'b0;
  bit            seen = 1'b0;

  // UART slave: logs each transfer, acks after ack_lat cycles
  always @(negedge clk) begin
    bus.s_ack_i = 1'b0;
    if (bus.s_stb_o === 1'b1) begin
      if (!prev_stb) begin
        log_q.push_back({bus.s_we_o, bus.s_adr_o, bus.s_dat_o});
        if (seen && idle_run < min_gap) min_gap = idle_run;
        seen = 1'b1;
        hi_len = 0;
      end
      hi_len++;
      if (!(nak_en && bus.s_adr_o == nak_adr) &&
          hi_len == ack_lat) begin
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = rd_val;
        ack_cyc = cyc;
        s_acks++;
      end
      prev_stb = 1'b1;
    end else begin
      if (prev_stb) begin
        last_len = hi_len;
        idle_run = 0;
      end
      idle_run++;
      prev_stb = 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic xfer_t cfg_exp(input int i,
                                    input logic [15:0] d);
    xfer_t x;
    x.we  = 1'b1;
    x.adr = AW'(2);
    x.dat = FCR;
    case (i)
      0: begin x.adr = AW'(3); x.dat = LCR | 8'h80; end
      1: begin x.adr = AW'(0); x.dat = d[7:0];      end
      2: begin x.adr = AW'(1); x.dat = d[15:8];     end
      3: begin x.adr = AW'(3); x.dat = LCR & 8'h7F; end
      default: ;
    endcase
    return x;
  endfunction

  task automatic chk_cfg(input string tag, input int base,
                         input int n, input logic [15:0] d);
    xfer_t got;
    for (int i = 0; i < n; i++) begin
      got = (base + i < log_q.size()) ? log_q[base + i] : '0;
      chk(tag, got, cfg_exp(i, d));
    end
  endtask

  task automatic cfg_kick(input logic [15:0] d);
    @(negedge clk);
    bus.cfg_start_i   = 1'b1;
    bus.cfg_divisor_i = d;
    @(negedge clk);
    bus.cfg_start_i   = 1'b0;
  endtask

  task automatic wait_cfg(input string tag);
    int n;
    n = 0;
    while (bus.cfg_busy_o && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < 1000, 1'b1);
    repeat (6) @(negedge clk);
  endtask

  task automatic host_op(input bit we, input logic [AW-1:0] adr,
                         input logic [7:0] wd, input bit kick,
                         input logic [15:0] d,
                         output bit ga, output bit ge,
                         output int ex, output int dc);
    @(negedge clk);
    bus.h_cyc_i = 1'b1;
    bus.h_stb_i = 1'b1;
    bus.h_we_i  = we;
    bus.h_adr_i = adr;
    bus.h_dat_i = wd;
    bus.cfg_start_i   = kick;
    bus.cfg_divisor_i = d;
    ga = 1'b0; ge = 1'b0; ex = 0; dc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.cfg_start_i = 1'b0;
      if (bus.h_ack_o || bus.h_err_o) begin
        ga = bus.h_ack_o;
        ge = bus.h_err_o;
        dc = cyc - ack_cyc;
        break;
      end
    end
    bus.h_cyc_i = 1'b0;
    bus.h_stb_i = 1'b0;
    bus.h_we_i  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.h_ack_o || bus.h_err_o) ex++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit         ga, ge, to, we;
    int         ex, dc, n, pulses;
    logic [7:0] last_hd, wd;
    logic [15:0] d;
    logic [AW-1:0] adr;

    bus.h_cyc_i = 1'b0;
    bus.h_stb_i = 1'b0;
    bus.h_we_i  = 1'b0;
    bus.h_adr_i = '0;
    bus.h_dat_i = '0;
    bus.cfg_start_i   = 1'b0;
    bus.cfg_divisor_i = '0;
    last_hd = 8'h00;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o,
         bus.s_dat_o, bus.h_dat_o, bus.h_ack_o, bus.h_err_o,
         bus.cfg_busy_o, bus.cfg_done_o, bus.cfg_err_o}, 0);

    // auto configuration after reset release
    rst_n = 1'b1;
    min_gap = 1000;
    seen = 1'b0;
    @(negedge clk);
    chk("auto_busy", bus.cfg_busy_o, 1'b1);
    wait_cfg("auto_bound");
    chk("auto_count", log_q.size(), 5);
    chk_cfg("auto_seq", 0, 5, RDIV);
    chk("auto_gap", min_gap >= 2, 1'b1);
    chk("auto_flags", {bus.cfg_busy_o, bus.cfg_done_o,
                       bus.cfg_err_o}, 3'b010);

    // host read
    log_q.delete();
    rd_val = 8'hA5;
    ack_lat = 2;
    host_op(1'b0, AW'(0), 8'h00, 1'b0, 16'h0, ga, ge, ex, dc);
    last_hd = 8'hA5;
    chk("rd_ack", {ga, ge}, 2'b10);
    chk("rd_ack_delay", dc, 1);
    chk("rd_ack_once", ex, 0);
    chk("rd_data", bus.h_dat_o, last_hd);
    chk("rd_xfer", log_q.size() == 1 ? log_q[0] : '0,
        {1'b0, AW'(0), 8'h00});

    // randomized host traffic, one forced timeout
    for (int i = 0; i < 8; i++) begin
      we      = 1'($urandom_range(0, 1));
      adr     = AW'($urandom_range(0, 7));
      wd      = 8'($urandom);
      rd_val  = 8'($urandom);
      ack_lat = $urandom_range(1, 4);
      to      = (i == 5);
      nak_en  = to;
      nak_adr = adr;
      log_q.delete();
      host_op(we, adr, wd, 1'b0, 16'h0, ga, ge, ex, dc);
      nak_en = 1'b0;
      if (to) begin
        last_hd = 8'h00;
        chk("rnd_to_resp", {ga, ge}, 2'b01);
        chk("rnd_to_len", last_len, 15);
      end else begin
        if (!we) last_hd = rd_val;
        chk("rnd_resp", {ga, ge}, 2'b10);
        chk("rnd_delay", dc, 1);
      end
      chk("rnd_once", ex, 0);
      chk("rnd_hdat", bus.h_dat_o, last_hd);
      chk("rnd_xfer", log_q.size() == 1 ? log_q[0] : '0,
          {we, adr, wd});
    end

    // config request wins over a simultaneous host write
    log_q.delete();
    ack_lat = 2;
    host_op(1'b1, AW'(4), 8'h5A, 1'b1, 16'h1234,
            ga, ge, ex, dc);
    chk("arb_resp", {ga, ge}, 2'b10);
    chk("arb_count", log_q.size(), 6);
    chk_cfg("arb_seq", 0, 5, 16'h1234);
    chk("arb_host_last", log_q.size() == 6 ? log_q[5] : '0,
        {1'b1, AW'(4), 8'h5A});
    chk("arb_done", bus.cfg_done_o, 1'b1);

    // no ack on DLM write: abort, then restart
    d = 16'($urandom);
    log_q.delete();
    nak_en  = 1'b1;
    nak_adr = AW'(1);
    cfg_kick(d);
    wait_cfg("abort_bound");
    nak_en = 1'b0;
    chk("abort_flags", {bus.cfg_busy_o, bus.cfg_done_o,
                        bus.cfg_err_o}, 3'b001);
    chk("abort_count", log_q.size(), 3);
    chk_cfg("abort_seq", 0, 3, d);
    chk("abort_len", last_len, 15);
    d = 16'($urandom);
    log_q.delete();
    cfg_kick(d);
    chk("restart_clr", {bus.cfg_busy_o, bus.cfg_err_o}, 2'b10);
    wait_cfg("restart_bound");
    chk("restart_flags", {bus.cfg_busy_o, bus.cfg_done_o,
                          bus.cfg_err_o}, 3'b010);
    chk("restart_count", log_q.size(), 5);
    chk_cfg("restart_seq", 0, 5, d);

    // host abandons a read
    log_q.delete();
    ack_lat = 3;
    rd_val  = 8'($urandom);
    s_acks  = 0;
    @(negedge clk);
    bus.h_cyc_i = 1'b1;
    bus.h_stb_i = 1'b1;
    bus.h_we_i  = 1'b0;
    bus.h_adr_i = AW'(0);
    @(negedge clk);
    bus.h_cyc_i = 1'b0;
    bus.h_stb_i = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.h_ack_o || bus.h_err_o) pulses++;
    end
    chk("drop_pulses", pulses, 0);
    chk("drop_xfers", log_q.size(), 1);
    chk("drop_slave_ack", s_acks, 1);
    chk("drop_len", last_len, 3);

    // reset during step 1
    ack_lat = 2;
    log_q.delete();
    cfg_kick(16'hBEEF);
    n = 0;
    while (!(log_q.size() == 2 && bus.s_stb_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_bound", n < 200, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs",
        {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o,
         bus.s_dat_o, bus.h_dat_o, bus.h_ack_o, bus.h_err_o,
         bus.cfg_busy_o, bus.cfg_done_o, bus.cfg_err_o}, 0);
    repeat (2) @(negedge clk);
    log_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_busy", bus.cfg_busy_o, 1'b1);
    wait_cfg("mid_bound2");
    chk("mid_count", log_q.size(), 5);
    chk_cfg("mid_seq", 0, 5, RDIV);
    chk("mid_done", bus.cfg_done_o, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/uart_wb_cfg_arb.md
Name: uart_wb_cfg_arb

Overview:
- Wishbone bus controller in front of the UART register port, used in its 8-bit data-bus configuration.
- Contains a configuration sequencer that programs the line-control, divisor-latch and FIFO-control registers after reset or on request.
- Arbitrates the single UART slave port between that sequencer and one external host master.
- Enforces inter-transfer gap cycles and guards every transfer with an ack timeout.

Parameters:
ADDR_WIDTH, 5, UART register address width
LCR_VAL, 8'h03, line-control value to program (8N1); DLAB bit is forced by the sequencer
FCR_VAL, 8'hC7, FIFO-control value (enable, clear both FIFOs, trigger level 14)
RESET_DIVISOR, 16'd27, divisor used by the automatic post-reset configuration
AUTO_CFG, 1, 1 = run the configuration sequence automatically when reset is released
GAP_CYCLES, 2, minimum idle cycles on the slave port between transfers
TIMEOUT, 15, maximum cycles the slave strobe is held without ack before the transfer aborts

Ports:
clk  in  1  system clock
wb_rst_n_i  in  1  reset, asynchronous, active-low
h_cyc_i  in  1  host cycle
h_stb_i  in  1  host strobe
h_we_i  in  1  host write enable
h_adr_i  in  ADDR_WIDTH  host address
h_dat_i  in  8  host write data
h_dat_o  out  8  host read data
h_ack_o  out  1  host ack, one-cycle pulse
h_err_o  out  1  host timeout error, one-cycle pulse
s_cyc_o  out  1  UART cycle
s_stb_o  out  1  UART strobe
s_we_o  out  1  UART write enable
s_adr_o  out  ADDR_WIDTH  UART address
s_dat_o  out  8  UART write data
s_dat_i  in  8  UART read data
s_ack_i  in  1  UART ack
cfg_start_i  in  1  configuration request pulse
cfg_divisor_i  in  16  divisor, sampled when a configuration is accepted
cfg_busy_o  out  1  configuration sequence in progress
cfg_done_o  out  1  sticky: last configuration completed
cfg_err_o  out  1  sticky: last configuration aborted on timeout

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0. With AUTO_CFG=1, cfg_busy_o rises on the first clock after reset release, using RESET_DIVISOR.
- Every slave-port output is registered. A transfer holds cyc, stb, we, adr and dat constant until s_ack_i or timeout; cyc and stb drop on the next edge.
- Arbiter FSM states: IDLE, HOST_XFER, CFG_XFER, GAP.
  - IDLE: if a configuration is pending -> CFG_XFER; else if h_cyc_i & h_stb_i -> HOST_XFER. Configuration wins when both are pending in the same cycle.
  - HOST_XFER / CFG_XFER: on s_ack_i, or when the timeout counter reaches TIMEOUT -> GAP.
  - GAP: counts GAP_CYCLES with cyc/stb low. Then goes to CFG_XFER if sequence steps remain, else IDLE.
- Configuration sequence (step counter 0-4), all writes:
  - step 0: adr 3 <= LCR_VAL|8'h80
  - step 1: adr 0 <= div[7:0]
  - step 2: adr 1 <= div[15:8]
  - step 3: adr 3 <= LCR_VAL&8'h7F
  - step 4: adr 2 <= FCR_VAL
- On step 4 ack: cfg_busy_o drops, cfg_done_o=1.
- On timeout at any step: the sequence aborts, cfg_busy_o drops, cfg_err_o=1, and remaining steps are skipped.
- Accepting cfg_start_i: it is latched as pending, clearing done and err.
  - If it arrives during HOST_XFER, the host transfer completes first.
  - If it arrives while cfg_busy_o is high, it is ignored.
  - A divisor of 0 is written as-is.
- Host transfer:
  - h_ack_o pulses one cycle after s_ack_i.
  - On reads, h_dat_o takes s_dat_i at that same edge and is held until the next host read.
  - On timeout, h_err_o pulses instead of h_ack_o and h_dat_o=0.
  - Host requests are stalled (no ack) while a configuration runs.
- Host drop mid-transfer: if h_cyc_i falls during HOST_XFER, the slave transfer still runs to ack or timeout, because aborting a UART read could lose a FIFO pop. The resulting h_ack_o/h_err_o is suppressed.
- Timeout counter: resets at each transfer start and saturates at TIMEOUT.
- Reset mid-operation: the slave strobe drops immediately (asynchronously). No partial state survives; with AUTO_CFG=1 the sequence restarts from step 0.

Test Plan:
1. Release reset, AUTO_CFG=1, slave acks 2 cycles after stb -> writes (3,8'h83),(0,8'h1B),(1,8'h00),(3,8'h03),(2,8'hC7) in order, each separated by ≥2 idle cycles; then cfg_done_o=1 and cfg_busy_o=0.
2. Host read adr 0, slave returns 8'hA5 -> exactly one h_ack_o pulse, one cycle after s_ack_i, with h_dat_o=8'hA5.
3. Assert cfg_start_i with divisor 16'h1234 in the same cycle as a host write request -> the configuration runs first, with DLL=8'h34 and DLM=8'h12; the host write to adr 4 is issued only after the sequence completes.
4. Slave never acks during step 2 -> stb drops after 15 cycles, cfg_err_o=1, cfg_done_o=0, and no step 3/4 writes occur. A subsequent cfg_start_i clears cfg_err_o and the sequence restarts from step 0.
5. Host drops h_cyc_i mid-read -> slave transfer completes, and neither h_ack_o nor h_err_o pulses.
6. Deassert wb_rst_n_i during step 1 -> all outputs go to 0 asynchronously. After release, the sequence restarts at step 0 with adr 3.
